// File: rtl/add_sub_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding,
// slice width helper and the result flag bundle.
package add_sub_pipe_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
   } flags_t;

   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/add_sub_slice.sv
// Combinational CHUNK-bit ripple adder: {c_out, sum} = x + y + c_in.
module add_sub_slice #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             c_in,
   output logic [CHUNK-1:0] sum,
   output logic             c_out
);

   logic [CHUNK:0] carry;

   assign carry[0] = c_in;

   for (genvar k = 0; k < CHUNK; k++) begin : g_bit
      full_adder u_fa (
         .a    (x[k]),
         .b    (y[k]),
         .cin  (carry[k]),
         .sum  (sum[k]),
         .cout (carry[k+1])
      );
   end

   assign c_out = carry[CHUNK];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, the building block of every ripple slice.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage with a
// registered carry between stages and valid/ready flow control per stage.
module add_sub_pipe
   import add_sub_pipe_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int CHUNK = chunk_width(WIDTH, STAGES);
   localparam int LAST  = STAGES - 1;
   localparam int MSB   = WIDTH - 1;

   if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("add_sub_pipe: STAGES must be >= 1 and divide WIDTH");
   end

   logic [STAGES-1:0] valid_q, valid_d;
   logic              carry_q [STAGES];
   logic              carry_d [STAGES];
   logic [WIDTH-1:0]  sum_q   [STAGES];
   logic [WIDTH-1:0]  sum_d   [STAGES];
   logic [WIDTH-1:0]  a_q     [STAGES];
   logic [WIDTH-1:0]  a_d     [STAGES];
   logic [WIDTH-1:0]  b_q     [STAGES];
   logic [WIDTH-1:0]  b_d     [STAGES];
   flags_t            flags_q, flags_d;

   logic [STAGES-1:0] stage_ready;
   logic [STAGES-1:0] up_valid;
   logic              up_carry  [STAGES];
   logic [WIDTH-1:0]  up_a      [STAGES];
   logic [WIDTH-1:0]  up_b      [STAGES];
   logic [WIDTH-1:0]  up_sum    [STAGES];
   logic [CHUNK-1:0]  slice_sum [STAGES];
   logic              slice_cout[STAGES];
   logic [WIDTH-1:0]  last_sum;

   // Stage 0 is fed straight from the ports with b already conditioned for subtract
   always_comb begin
      up_valid[0] = in_valid;
      up_a[0]     = a;
      up_b[0]     = (sub == OP_ADD) ? b : ~b;
      up_carry[0] = cin ^ (sub == OP_SUB);
      up_sum[0]   = '0;
      for (int i = 1; i < STAGES; i++) begin
         up_valid[i] = valid_q[i-1];
         up_a[i]     = a_q[i-1];
         up_b[i]     = b_q[i-1];
         up_carry[i] = carry_q[i-1];
         up_sum[i]   = sum_q[i-1];
      end
   end

   // A stage can load unless it and everything after it is full and the consumer stalls
   always_comb begin
      logic full_tail;
      full_tail   = 1'b1;
      stage_ready = '0;
      for (int i = 0; i < STAGES; i++) begin
         full_tail = 1'b1;
         for (int j = i; j < STAGES; j++) begin
            full_tail = full_tail & valid_q[j];
         end
         stage_ready[i] = out_ready || !full_tail;
      end
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      add_sub_slice #(.CHUNK(CHUNK)) u_slice (
         .x     (up_a[i][i*CHUNK +: CHUNK]),
         .y     (up_b[i][i*CHUNK +: CHUNK]),
         .c_in  (up_carry[i]),
         .sum   (slice_sum[i]),
         .c_out (slice_cout[i])
      );
   end

   always_comb begin
      valid_d  = valid_q;
      carry_d  = carry_q;
      sum_d    = sum_q;
      a_d      = a_q;
      b_d      = b_q;
      flags_d  = flags_q;
      last_sum = up_sum[LAST];
      last_sum[LAST*CHUNK +: CHUNK] = slice_sum[LAST];
      for (int i = 0; i < STAGES; i++) begin
         if (stage_ready[i]) begin
            valid_d[i] = up_valid[i];
            if (up_valid[i]) begin
               carry_d[i] = slice_cout[i];
               sum_d[i]   = up_sum[i];
               sum_d[i][i*CHUNK +: CHUNK] = slice_sum[i];
               a_d[i]     = up_a[i];
               b_d[i]     = up_b[i];
            end
         end
      end
      // Flags are only known once the top slice has produced the sign bit
      if (stage_ready[LAST] && up_valid[LAST]) begin
         flags_d.cout = slice_cout[LAST];
         flags_d.ovf  = (up_a[LAST][MSB] == up_b[LAST][MSB]) &&
                        (last_sum[MSB] != up_a[LAST][MSB]);
         flags_d.zero = (last_sum == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         flags_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            carry_q[i] <= 1'b0;
            sum_q[i]   <= '0;
            a_q[i]     <= '0;
            b_q[i]     <= '0;
         end
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         a_q     <= a_d;
         b_q     <= b_d;
         flags_q <= flags_d;
      end
   end

   assign in_ready  = stage_ready[0];
   assign out_valid = valid_q[LAST];
   assign s         = sum_q[LAST];
   assign cout      = flags_q.cout;
   assign ovf       = flags_q.ovf;
   assign zero      = flags_q.zero;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Self-checking bench for add_sub_pipe: directed vectors, back-pressure,
// asynchronous reset mid-stream and exhaustive 4-bit runs against a model.
module tb_add_sub_pipe;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // 16-bit, 4-stage instance driven by the directed tests
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready;
   logic        cout, ovf, zero;
   logic [15:0] a, b, s;

   add_sub_pipe #(.WIDTH(16), .STAGES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   // Two 4-bit instances share one stimulus stream for the exhaustive run
   logic       x_valid, x_cin, x_sub, x_ready;
   logic [3:0] x_a, x_b;
   logic       p4_in_ready, p4_out_valid, p4_cout, p4_ovf, p4_zero;
   logic [3:0] p4_s;
   logic       p1_in_ready, p1_out_valid, p1_cout, p1_ovf, p1_zero;
   logic [3:0] p1_s;

   add_sub_pipe #(.WIDTH(4), .STAGES(4)) dut_w4s4 (
      .clk (clk), .rst_n (rst_n), .in_valid (x_valid), .in_ready (p4_in_ready),
      .a (x_a), .b (x_b), .cin (x_cin), .sub (x_sub),
      .out_valid (p4_out_valid), .out_ready (x_ready),
      .s (p4_s), .cout (p4_cout), .ovf (p4_ovf), .zero (p4_zero)
   );

   add_sub_pipe #(.WIDTH(4), .STAGES(1)) dut_w4s1 (
      .clk (clk), .rst_n (rst_n), .in_valid (x_valid), .in_ready (p1_in_ready),
      .a (x_a), .b (x_b), .cin (x_cin), .sub (x_sub),
      .out_valid (p1_out_valid), .out_ready (x_ready),
      .s (p1_s), .cout (p1_cout), .ovf (p1_ovf), .zero (p1_zero)
   );

   int checks = 0;
   int fails  = 0;

   // Every comparison in the bench goes through here
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model from integer arithmetic: returns {zero, ovf, cout, s[15:0]}
   function automatic logic [18:0] refModel(input int w, input int av, input int bv,
                                            input int c, input int sb);
      int   r, sa, sbv, rs, mask, half;
      logic rc, rv, rz;
      mask = (1 << w) - 1;
      half = 1 << (w - 1);
      r    = (sb != 0) ? av - bv - c : av + bv + c;
      rc   = (sb != 0) ? (r >= 0) : (r > mask);
      sa   = (av >= half) ? av - (1 << w) : av;
      sbv  = (bv >= half) ? bv - (1 << w) : bv;
      rs   = (sb != 0) ? sa - sbv - c : sa + sbv + c;
      rv   = (rs >= half) || (rs < -half);
      rz   = ((r & mask) == 0);
      return {rz, rv, rc, 16'(r & mask)};
   endfunction

   // Scoreboards: expected results queued on accept, compared in order on delivery
   logic [18:0] exp_main [$];
   logic [18:0] exp_p4   [$];
   logic [18:0] exp_p1   [$];
   logic [18:0] e;
   int accepted_main = 0, delivered_main = 0, delivered_p4 = 0, delivered_p1 = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_main.delete();
         exp_p4.delete();
         exp_p1.delete();
      end else begin
         if (in_valid && in_ready) begin
            exp_main.push_back(refModel(16, int'(a), int'(b), int'(cin), int'(sub)));
            accepted_main++;
         end
         if (out_valid && out_ready) begin
            delivered_main++;
            checkOutput("sb_main_pending", exp_main.size() > 0, 1);
            if (exp_main.size() > 0) begin
               e = exp_main.pop_front();
               checkOutput("sb_main_s", s, e[15:0]);
               checkOutput("sb_main_cout", cout, e[16]);
               checkOutput("sb_main_ovf", ovf, e[17]);
               checkOutput("sb_main_zero", zero, e[18]);
            end
         end
         if (x_valid && p4_in_ready)
            exp_p4.push_back(refModel(4, int'(x_a), int'(x_b), int'(x_cin), int'(x_sub)));
         if (x_valid && p1_in_ready)
            exp_p1.push_back(refModel(4, int'(x_a), int'(x_b), int'(x_cin), int'(x_sub)));
         if (p4_out_valid) begin
            delivered_p4++;
            checkOutput("sb_w4s4_pending", exp_p4.size() > 0, 1);
            if (exp_p4.size() > 0) begin
               e = exp_p4.pop_front();
               checkOutput("sb_w4s4_s", p4_s, e[3:0]);
               checkOutput("sb_w4s4_cout", p4_cout, e[16]);
               checkOutput("sb_w4s4_ovf", p4_ovf, e[17]);
               checkOutput("sb_w4s4_zero", p4_zero, e[18]);
            end
         end
         if (p1_out_valid) begin
            delivered_p1++;
            checkOutput("sb_w4s1_pending", exp_p1.size() > 0, 1);
            if (exp_p1.size() > 0) begin
               e = exp_p1.pop_front();
               checkOutput("sb_w4s1_s", p1_s, e[3:0]);
               checkOutput("sb_w4s1_cout", p1_cout, e[16]);
               checkOutput("sb_w4s1_ovf", p1_ovf, e[17]);
               checkOutput("sb_w4s1_zero", p1_zero, e[18]);
            end
         end
      end
   end

   // Offer one operand set to the 16-bit instance; called and returns at posedge+1
   task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                input logic c, input logic sb);
      int guard;
      bit accepted;
      guard    = 0;
      accepted = 1'b0;
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      cin      = c;
      sub      = sb;
      while (!accepted && guard < 50) begin
         @(negedge clk);
         accepted = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      in_valid = 1'b0;
      checkOutput("accept", accepted, 1);
   endtask

   // One isolated operation: latency counted in cycles after the accepting edge
   task automatic runSingle(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic c, input logic sb, input logic [15:0] es,
                            input logic ec, input logic eo, input logic ez);
      int lat;
      lat       = 0;
      out_ready = 1'b1;
      applyStimulus(av, bv, c, sb);
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      checkOutput($sformatf("%s_latency", tag), lat, 4);
      checkOutput($sformatf("%s_s", tag), s, es);
      checkOutput($sformatf("%s_cout", tag), cout, ec);
      checkOutput($sformatf("%s_ovf", tag), ovf, eo);
      checkOutput($sformatf("%s_zero", tag), zero, ez);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      int stale;
      int base;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      x_valid   = 1'b0;
      x_a       = '0;
      x_b       = '0;
      x_cin     = 1'b0;
      x_sub     = 1'b0;
      x_ready   = 1'b1;

      // Reset values while rst_n is held low
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_in_ready", in_ready, 1);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_s", s, 16'h0000);
      checkOutput("reset_cout", cout, 0);
      checkOutput("reset_ovf", ovf, 0);
      checkOutput("reset_zero", zero, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_in_ready", in_ready, 1);
      checkOutput("post_reset_out_valid", out_valid, 0);
      @(posedge clk);
      #1;

      $display("[TB] directed add/subtract vectors");
      runSingle("add_basic",  16'h1234, 16'h0FF0, 1'b0, 1'b0, 16'h2224, 1'b0, 1'b0, 1'b0);
      runSingle("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      runSingle("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      runSingle("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      runSingle("sub_cin",    16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
      runSingle("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      runSingle("sub_zero",   16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

      $display("[TB] back-pressure with a bubble");
      out_ready = 1'b1;
      base      = delivered_main;
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               if (k == 2) begin
                  @(posedge clk);
                  #1;
               end
               applyStimulus(16'(16'h1000 * (k + 1)), 16'(16'h0101 * k), 1'b0, 1'b0);
            end
         end
         begin
            int g;
            g = 0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            do begin
               @(negedge clk);
               g++;
            end while (in_ready && g < 50);
            checkOutput("bp_in_ready_low", in_ready, 0);
            checkOutput("bp_occupancy", accepted_main - delivered_main, 4);
            repeat (3) begin
               @(negedge clk);
               checkOutput("bp_hold_valid", out_valid, 1);
               checkOutput("bp_hold_s", s, 16'h1000);
               checkOutput("bp_hold_cout", cout, 0);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      guard = 0;
      while (delivered_main - base < 8 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("bp_delivered", delivered_main - base, 8);
      @(posedge clk);
      #1;

      $display("[TB] asynchronous reset with three operations in flight");
      out_ready = 1'b0;
      applyStimulus(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
      applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0);
      applyStimulus(16'h0003, 16'h0004, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_pre_valid", out_valid, 1);
      checkOutput("rst_pre_s", s, 16'hFFFE);
      checkOutput("rst_pre_ovf", ovf, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_async_valid", out_valid, 0);
      checkOutput("rst_async_s", s, 16'h0000);
      checkOutput("rst_async_cout", cout, 0);
      checkOutput("rst_async_ovf", ovf, 0);
      checkOutput("rst_async_zero", zero, 0);
      checkOutput("rst_async_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      stale     = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      checkOutput("rst_no_stale", stale, 0);
      checkOutput("rst_in_ready_after", in_ready, 1);
      @(posedge clk);
      #1;

      $display("[TB] exhaustive 4-bit runs");
      for (int av = 0; av < 16; av++) begin
         for (int bv = 0; bv < 16; bv++) begin
            for (int c = 0; c < 2; c++) begin
               for (int sb = 0; sb < 2; sb++) begin
                  x_valid = 1'b1;
                  x_a     = 4'(av);
                  x_b     = 4'(bv);
                  x_cin   = 1'(c);
                  x_sub   = 1'(sb);
                  @(posedge clk);
                  #1;
               end
            end
         end
      end
      x_valid = 1'b0;
      guard   = 0;
      while ((delivered_p4 < 1024 || delivered_p1 < 1024) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("w4s4_count", delivered_p4, 1024);
      checkOutput("w4s1_count", delivered_p1, 1024);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
